pll_reset_sequencer: RTL and testbench

Supervises the on-chip rPLL wrapper: holds the PLL in reset, waits for LOCK, qualifies it as stable, then releases the active-low system reset to the PicoRV32 core and peripherals. It runs on the raw 27 MHz board clock, never on the PLL output. On lock loss or a software relock request it re-sequences the PLL. After repeated lock timeouts it parks in a fault state.

---
 rtl/pll_reset_sequencer_pkg.sv | 31 +++
 rtl/pll_reset_sequencer_if.sv | 20 ++
 rtl/pll_reset_sequencer_sync_2ff.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 125 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    SYS_RST   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } seq_state_t;

  // Defaults for the 27 MHz board clock.
  localparam int PLL_RST_CYCLES_DEF     = 16;
  localparam int LOCK_TIMEOUT_DEF       = 27000;
  localparam int LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int SYS_RST_CYCLES_DEF     = 64;
  localparam int MAX_RETRIES_DEF        = 3;

  // Timer width: one bit of headroom over the longest interval so the
  // terminal count never aliases with a wrapped value.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and system-side signals of the reset sequencer.
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       sys_resetn;
  logic       locked;
  logic       fault;
  logic [3:0] retry_count;

  modport master (
    input  pll_lock, relock_req,
    output pll_reset, sys_resetn, locked, fault, retry_count
  );

  modport slave (
    output pll_lock, relock_req,
    input  pll_reset, sys_resetn, locked, fault, retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs (PLL lock, UART RX, ...).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; q is valid two edges after d changes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: resets the PLL, qualifies LOCK, then releases the
// system reset. Runs on the raw board clock.
//
// state     | meaning
// PLL_RST   | pll_reset held high for PLL_RST_CYCLES
// WAIT_LOCK | waiting for lock_s, bounded by LOCK_TIMEOUT
// STABLE    | lock_s must stay high LOCK_STABLE_CYCLES in a row
// SYS_RST   | lock qualified, sys_resetn still low SYS_RST_CYCLES
// RUN       | system out of reset
// FAULT     | too many timeouts, waits for relock_req or resetn
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = PLL_RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT       = LOCK_TIMEOUT_DEF,
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int SYS_RST_CYCLES     = SYS_RST_CYCLES_DEF,
  parameter int MAX_RETRIES        = MAX_RETRIES_DEF
) (
  input logic                    clk,
  input logic                    resetn,
  pll_reset_sequencer_if.master  pll_io
);
  localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                  LOCK_STABLE_CYCLES, SYS_RST_CYCLES);

  localparam logic [TW-1:0] PLL_RST_TC = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_TC = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_TC  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] SYS_RST_TC = TW'(SYS_RST_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

  seq_state_t    state, state_nx;
  logic [TW-1:0] timer;
  logic          restart;
  logic          lock_s;
  logic [3:0]    retry_q, retry_nx;
  logic          pll_reset_q, sys_resetn_q, locked_q, fault_q;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_io.pll_lock),
    .q      (lock_s)
  );

  // Next-state and retry bookkeeping; relock_req has priority everywhere.
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    retry_nx = retry_q;
    case (state)
      PLL_RST: begin
        if (pll_io.relock_req)     restart  = 1'b1;
        else if (timer == PLL_RST_TC) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (pll_io.relock_req)     state_nx = PLL_RST;
        else if (lock_s)           state_nx = STABLE;
        else if (timer == TIMEOUT_TC) begin
          retry_nx = retry_q + 4'd1;
          state_nx = (retry_nx == RETRY_MAX) ? FAULT : PLL_RST;
        end
      end
      STABLE: begin
        if (pll_io.relock_req)     state_nx = PLL_RST;
        else if (!lock_s)          state_nx = WAIT_LOCK;
        else if (timer == STABLE_TC) state_nx = SYS_RST;
      end
      SYS_RST: begin
        if (pll_io.relock_req)     state_nx = PLL_RST;
        else if (timer == SYS_RST_TC) begin
          state_nx = RUN;
          retry_nx = 4'd0;
        end
      end
      RUN: begin
        if (pll_io.relock_req || !lock_s) state_nx = PLL_RST;
      end
      FAULT: begin
        if (pll_io.relock_req) begin
          state_nx = PLL_RST;
          retry_nx = 4'd0;
        end
      end
      default: state_nx = PLL_RST;
    endcase
  end

  // State register and shared timer; timer clears on every state entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= PLL_RST;
      timer <= '0;
    end else begin
      state <= state_nx;
      if (restart || (state_nx != state)) timer <= '0;
      else                                timer <= timer + 1'b1;
    end
  end

  // Outputs registered from the next state so they align with the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pll_reset_q  <= 1'b1;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      retry_q      <= 4'd0;
    end else begin
      pll_reset_q  <= (state_nx == PLL_RST) || (state_nx == FAULT);
      sys_resetn_q <= (state_nx == RUN);
      locked_q     <= (state_nx == SYS_RST) || (state_nx == RUN);
      fault_q      <= (state_nx == FAULT);
      retry_q      <= retry_nx;
    end
  end

  assign pll_io.pll_reset   = pll_reset_q;
  assign pll_io.sys_resetn  = sys_resetn_q;
  assign pll_io.locked      = locked_q;
  assign pll_io.fault       = fault_q;
  assign pll_io.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short cycle parameters.
module tb_pll_reset_sequencer;
  logic clk;
  logic resetn;
  int   n_chk  = 0;
  int   n_pass = 0;

  pll_reset_sequencer_if sif ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (32),
    .LOCK_STABLE_CYCLES (8),
    .SYS_RST_CYCLES     (4),
    .MAX_RETRIES        (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .pll_io (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    sif.pll_lock   = 1'b0;
    sif.relock_req = 1'b0;
    tick(2);
    resetn = 1'b1;
  endtask

  // Call right after pll_lock rises (just past an edge). First sample edge
  // is E0; locked rises at E10, sys_resetn at E14.
  task automatic expect_bringup(input string tag);
    tick(10);
    check_val({tag, " locked_e9"}, int'(sif.locked), 0);
    tick(1);
    check_val({tag, " locked_e10"}, int'(sif.locked), 1);
    check_val({tag, " sysrst_e10"}, int'(sif.sys_resetn), 0);
    tick(3);
    check_val({tag, " sysrst_e13"}, int'(sif.sys_resetn), 0);
    tick(1);
    check_val({tag, " sysrst_e14"}, int'(sif.sys_resetn), 1);
    check_val({tag, " retry_e14"}, int'(sif.retry_count), 0);
    check_val({tag, " pllrst_e14"}, int'(sif.pll_reset), 0);
  endtask

  initial begin
    int bad;
    resetn = 1'b1;
    sif.pll_lock   = 1'b0;
    sif.relock_req = 1'b0;
    #3 resetn = 1'b0;
    #1;
    check_val("rst pll_reset",  int'(sif.pll_reset), 1);
    check_val("rst sys_resetn", int'(sif.sys_resetn), 0);
    check_val("rst locked",     int'(sif.locked), 0);
    check_val("rst fault",      int'(sif.fault), 0);
    check_val("rst retry",      int'(sif.retry_count), 0);

    // 1. normal bring-up
    tick(2);
    resetn = 1'b1;
    tick(3);
    check_val("s1 pllrst_c3", int'(sif.pll_reset), 1);
    tick(1);
    check_val("s1 pllrst_c4", int'(sif.pll_reset), 0);
    tick(6);
    sif.pll_lock = 1'b1;
    expect_bringup("s1");

    // 2. glitchy lock
    do_reset();
    tick(4);
    sif.pll_lock = 1'b1;
    tick(5);
    sif.pll_lock = 1'b0;
    tick(1);
    sif.pll_lock = 1'b1;
    expect_bringup("s2");

    // 3. timeout and fault
    do_reset();
    tick(35);
    check_val("s3 retry_c35",  int'(sif.retry_count), 0);
    check_val("s3 pllrst_c35", int'(sif.pll_reset), 0);
    tick(1);
    check_val("s3 retry_c36",  int'(sif.retry_count), 1);
    check_val("s3 pllrst_c36", int'(sif.pll_reset), 1);
    check_val("s3 fault_c36",  int'(sif.fault), 0);
    tick(35);
    check_val("s3 fault_c71",  int'(sif.fault), 0);
    tick(1);
    check_val("s3 fault_c72",  int'(sif.fault), 1);
    check_val("s3 retry_c72",  int'(sif.retry_count), 2);
    check_val("s3 pllrst_c72", int'(sif.pll_reset), 1);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (sif.pll_reset !== 1'b1 || sif.sys_resetn !== 1'b0 || sif.fault !== 1'b1) bad++;
    end
    check_val("s3 fault_hold_bad", bad, 0);

    // 4. recovery from fault
    sif.relock_req = 1'b1;
    tick(1);
    sif.relock_req = 1'b0;
    check_val("s4 fault",  int'(sif.fault), 0);
    check_val("s4 retry",  int'(sif.retry_count), 0);
    check_val("s4 pllrst", int'(sif.pll_reset), 1);
    tick(3);
    check_val("s4 pllrst_c3", int'(sif.pll_reset), 1);
    tick(1);
    check_val("s4 pllrst_c4", int'(sif.pll_reset), 0);
    sif.pll_lock = 1'b1;
    expect_bringup("s4");

    // 5. lock loss in RUN
    sif.pll_lock = 1'b0;
    tick(2);
    check_val("s5 sysrst_d2", int'(sif.sys_resetn), 1);
    check_val("s5 locked_d2", int'(sif.locked), 1);
    tick(1);
    check_val("s5 sysrst_d3", int'(sif.sys_resetn), 0);
    check_val("s5 locked_d3", int'(sif.locked), 0);
    check_val("s5 pllrst_d3", int'(sif.pll_reset), 1);
    tick(3);
    check_val("s5 pllrst_c3", int'(sif.pll_reset), 1);
    tick(1);
    check_val("s5 pllrst_c4", int'(sif.pll_reset), 0);
    sif.pll_lock = 1'b1;

    // 6. mid-sequence reset during SYS_RST
    tick(12);
    check_val("s6 in_sysrst locked", int'(sif.locked), 1);
    resetn = 1'b0;
    #2;
    check_val("s6 async pllrst", int'(sif.pll_reset), 1);
    check_val("s6 async locked", int'(sif.locked), 0);
    check_val("s6 async sysrst", int'(sif.sys_resetn), 0);
    check_val("s6 async retry",  int'(sif.retry_count), 0);
    tick(1);
    resetn = 1'b1;
    tick(4);
    check_val("s6 pllrst_c4", int'(sif.pll_reset), 0);
    tick(8);
    check_val("s6 locked_c12", int'(sif.locked), 0);
    tick(1);
    check_val("s6 locked_c13", int'(sif.locked), 1);
    tick(3);
    check_val("s6 sysrst_c16", int'(sif.sys_resetn), 0);
    tick(1);
    check_val("s6 sysrst_c17", int'(sif.sys_resetn), 1);

    // 6b. relock_req in the same cycle that lock_s drops in RUN
    sif.pll_lock = 1'b0;
    tick(2);
    sif.relock_req = 1'b1;
    tick(1);
    sif.relock_req = 1'b0;
    check_val("s6b sysrst", int'(sif.sys_resetn), 0);
    check_val("s6b pllrst", int'(sif.pll_reset), 1);
    tick(3);
    check_val("s6b pllrst_c3", int'(sif.pll_reset), 1);
    tick(1);
    check_val("s6b pllrst_c4", int'(sif.pll_reset), 0);

    // 7. lock arrives on the exact timeout cycle: lock wins
    do_reset();
    tick(33);
    sif.pll_lock = 1'b1;
    expect_bringup("s7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
